// File: rtl/board_motion_if.sv
// Pixel/frame bus between the video timing logic and the moving-platform locator.
// master drives the frame strobe, trigger and pixel coordinates; slave returns board position and pixel hit.
interface board_motion_if;
    logic       frame_clk;
    logic       trigger;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] board_y;
    logic       moving;
    logic       is_board;
    logic [9:0] board_address;

    modport master (
        output frame_clk, trigger, DrawX, DrawY,
        input  board_y, moving, is_board, board_address
    );

    modport slave (
        input  frame_clk, trigger, DrawX, DrawY,
        output board_y, moving, is_board, board_address
    );
endinterface

// File: rtl/board_motion.sv
// Moving platform: slides between Y_TOP and Y_BOT one STEP per frame tick, plus zero-latency pixel locator.
// Optional macro BOARD_HOLD_EN keeps the board at the bottom for HOLD_FRAMES ticks after arrival.
module board_motion #(
    parameter int BOARD_X = 556,
    parameter int BOARD_W = 68,
    parameter int BOARD_H = 12,
    parameter int Y_TOP   = 204,
    parameter int Y_BOT   = 252,
    parameter int STEP    = 2
`ifdef BOARD_HOLD_EN
    , parameter int HOLD_FRAMES = 30
`endif
) (
    input logic          Clk,
    input logic          Reset,
    board_motion_if.slave bus
);

    typedef enum logic [1:0] {REST_TOP, DOWN, REST_BOT, UP} state_t;

    state_t     state_q, state_d;
    logic [9:0] board_y_q, board_y_d;
    logic       moving_q, moving_d;
    logic       frame_q, frame_d;
    logic       tick;
    logic [10:0] y_ext;

`ifdef BOARD_HOLD_EN
    localparam int HCW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
    logic [HCW-1:0] hold_q, hold_d;
    logic           hold_done;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= REST_TOP;
            board_y_q <= 10'(Y_TOP);
            moving_q  <= 1'b0;
            frame_q   <= 1'b0;
`ifdef BOARD_HOLD_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            board_y_q <= board_y_d;
            moving_q  <= moving_d;
            frame_q   <= frame_d;
`ifdef BOARD_HOLD_EN
            hold_q    <= hold_d;
`endif
        end
    end

    // Direction changes cost a whole frame: the reversing tick only switches state.
    always_comb begin
        frame_d   = bus.frame_clk;
        tick      = bus.frame_clk & ~frame_q;
        state_d   = state_q;
        board_y_d = board_y_q;
        y_ext     = {1'b0, board_y_q};
`ifdef BOARD_HOLD_EN
        hold_d    = hold_q;
        hold_done = (hold_q == '0);
`endif
        if (tick) begin
            case (state_q)
                REST_TOP: begin
                    if (bus.trigger) state_d = DOWN;
                end
                DOWN: begin
                    if (!bus.trigger) begin
                        state_d = UP;
                    end else if (y_ext + 11'(STEP) >= 11'(Y_BOT)) begin
                        board_y_d = 10'(Y_BOT);
                        state_d   = REST_BOT;
`ifdef BOARD_HOLD_EN
                        hold_d    = HCW'(HOLD_FRAMES);
`endif
                    end else begin
                        board_y_d = board_y_q + 10'(STEP);
                    end
                end
                REST_BOT: begin
`ifdef BOARD_HOLD_EN
                    if (!bus.trigger && hold_done) state_d = UP;
                    else if (!hold_done)           hold_d  = hold_q - HCW'(1);
`else
                    if (!bus.trigger) state_d = UP;
`endif
                end
                UP: begin
                    if (bus.trigger) begin
                        state_d = DOWN;
                    end else if (y_ext <= 11'(Y_TOP + STEP)) begin
                        board_y_d = 10'(Y_TOP);
                        state_d   = REST_TOP;
                    end else begin
                        board_y_d = board_y_q - 10'(STEP);
                    end
                end
                default: state_d = REST_TOP;
            endcase
        end
        moving_d = (state_d == DOWN) || (state_d == UP);
    end

    // Pixel locator works off the registered board_y so a whole frame sees one position.
    logic       x_in, y_in;
    logic [10:0] draw_x_ext, draw_y_ext, by_ext;
    logic [9:0] dx, dy, addr;

    always_comb begin
        draw_x_ext = {1'b0, bus.DrawX};
        draw_y_ext = {1'b0, bus.DrawY};
        by_ext     = {1'b0, board_y_q};
        x_in = (draw_x_ext >= 11'(BOARD_X)) && (draw_x_ext < 11'(BOARD_X + BOARD_W));
        y_in = (draw_y_ext >= by_ext) && (draw_y_ext < by_ext + 11'(BOARD_H));
        dx   = bus.DrawX - 10'(BOARD_X);
        dy   = bus.DrawY - board_y_q;
        addr = dx + dy * 10'(BOARD_W);
    end

    assign bus.board_y       = board_y_q;
    assign bus.moving        = moving_q;
    assign bus.is_board      = x_in && y_in;
    assign bus.board_address = (x_in && y_in) ? addr : 10'd0;

endmodule

// File: tb/tb_board_motion.sv
// Directed bench for board_motion: pixel-locator vector table plus hand-written motion sequences.
module tb_board_motion;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    board_motion_if bm_if ();

    board_motion u_dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bm_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       isb;
        logic [9:0] addr;
    } pix_vec_t;

    pix_vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame strobe pulse; returns at a negedge after the tick edge has been taken.
    task automatic frame_tick();
        @(negedge clk);
        bm_if.frame_clk = 1'b1;
        @(negedge clk);
        bm_if.frame_clk = 1'b0;
    endtask

    task automatic check_pos(input string name, input int y, input logic mv);
        check({name, "_y"}, 32'(bm_if.board_y), 32'(y));
        check({name, "_moving"}, 32'(bm_if.moving), 32'(mv));
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            bm_if.DrawX = vecs[i].x;
            bm_if.DrawY = vecs[i].y;
            #1;
            check($sformatf("pix%0d_is_board", i), 32'(bm_if.is_board), 32'(vecs[i].isb));
            check($sformatf("pix%0d_addr", i), 32'(bm_if.board_address), 32'(vecs[i].addr));
        end
    endtask

    initial begin
        // board_y = 204
        vecs[0]  = '{10'd556, 10'd204, 1'b1, 10'd0};
        vecs[1]  = '{10'd555, 10'd204, 1'b0, 10'd0};
        vecs[2]  = '{10'd623, 10'd204, 1'b1, 10'd67};
        vecs[3]  = '{10'd624, 10'd204, 1'b0, 10'd0};
        vecs[4]  = '{10'd556, 10'd215, 1'b1, 10'd748};
        vecs[5]  = '{10'd556, 10'd216, 1'b0, 10'd0};
        vecs[6]  = '{10'd600, 10'd210, 1'b1, 10'd452};
        vecs[7]  = '{10'd556, 10'd203, 1'b0, 10'd0};
        // board_y = 252
        vecs[8]  = '{10'd623, 10'd263, 1'b1, 10'd815};
        vecs[9]  = '{10'd623, 10'd264, 1'b0, 10'd0};
        vecs[10] = '{10'd556, 10'd252, 1'b1, 10'd0};
        vecs[11] = '{10'd556, 10'd251, 1'b0, 10'd0};

        reset           = 1'b1;
        bm_if.frame_clk = 1'b0;
        bm_if.trigger   = 1'b0;
        bm_if.DrawX     = 10'd0;
        bm_if.DrawY     = 10'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_pos("reset", 204, 1'b0);
        apply_vecs(0, 7);

        // Trigger pulse between ticks is ignored; trigger low at the tick keeps REST_TOP.
        @(negedge clk); bm_if.trigger = 1'b1;
        @(negedge clk); bm_if.trigger = 1'b0;
        frame_tick();
        check_pos("glitch", 204, 1'b0);

        // Descend: first tick only enters DOWN, then 24 steps of 2 reach 252.
        bm_if.trigger = 1'b1;
        frame_tick();
        check_pos("down_t1", 204, 1'b1);
        for (int k = 2; k <= 25; k++) begin
            frame_tick();
            check_pos($sformatf("down_t%0d", k), 204 + 2 * (k - 1), (k < 25));
        end
        apply_vecs(8, 11);

        // Release at once at the bottom.
        bm_if.trigger = 1'b0;
`ifdef BOARD_HOLD_EN
        for (int k = 1; k <= 30; k++) begin
            frame_tick();
            check_pos($sformatf("hold_t%0d", k), 252, 1'b0);
        end
`endif
        frame_tick();
        check_pos("release", 252, 1'b1);

        // Ascend 23 steps to 206, then snap to rest at 204.
        for (int k = 1; k <= 23; k++) frame_tick();
        check_pos("up_206", 206, 1'b1);
        frame_tick();
        check_pos("up_rest", 204, 1'b0);

        // Down to 220, reverse, then reverse again.
        bm_if.trigger = 1'b1;
        for (int k = 1; k <= 9; k++) frame_tick();
        check_pos("down_220", 220, 1'b1);
        bm_if.trigger = 1'b0;
        frame_tick();
        check_pos("rev_up", 220, 1'b1);
        frame_tick();
        check_pos("rev_218", 218, 1'b1);
        bm_if.trigger = 1'b1;
        frame_tick();
        check_pos("rev_down", 218, 1'b1);
        for (int k = 1; k <= 11; k++) frame_tick();
        check_pos("down_240", 240, 1'b1);

        // Reset mid-motion.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_pos("mid_reset", 204, 1'b0);
        frame_tick();
        check_pos("after_reset", 204, 1'b1);
        frame_tick();
        check_pos("after_reset2", 206, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_motion.md
Name: board_motion

Overview:
Position controller and pixel locator for the purple moving platform. It slides the 68x12 platform vertically between a top rest row and a bottom rest row, one step per video frame, driven by a player-operated trigger such as a pressure button. It outputs the current board row, plus is_board and board_address for the current pixel, and feeds board_rom and the colour mapper directly. It replaces the fixed-position locator.

Parameters:
BOARD_X, 556, left column of board (fixed)
BOARD_W, 68, board width in pixels
BOARD_H, 12, board height in pixels
Y_TOP, 204, top rest row (board_y at reset)
Y_BOT, 252, bottom rest row; Y_BOT > Y_TOP, (Y_BOT - Y_TOP) multiple of STEP
STEP, 2, rows moved per frame tick
HOLD_FRAMES, 30, frames held at bottom (BOARD_HOLD_EN only)

Ports:
Clk  in  1  system clock (single clock domain)
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  vertical-sync-derived frame strobe, synchronous to Clk
trigger  in  1  1 = player on button, so board goes down; 0 = board returns up
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
board_y  out  10  registered top row of board
moving  out  1  registered; 1 while in state DOWN or UP
is_board  out  1  combinational; current pixel lies inside board
board_address  out  10  combinational ROM address; 0 when is_board = 0

Behaviour:
- Interface: one clock Clk; Reset is synchronous and active-high.
- Reset (sampled on Clk rising edge): board_y = Y_TOP, state = REST_TOP, moving = 0, frame edge register = 0, hold counter = 0.
- Frame tick: frame_clk is registered each Clk. tick = frame_clk & ~frame_clk_q, so it lasts one Clk cycle per rising edge. All state changes and board_y updates happen only on Clk edges where tick = 1.
- States: REST_TOP, DOWN, REST_BOT, UP.
- REST_TOP: on tick with trigger = 1, go to DOWN. board_y is unchanged on this tick.
- DOWN, on tick:
  - trigger = 0: go to UP. board_y is unchanged on this tick (reversal costs one frame).
  - otherwise, if board_y + STEP >= Y_BOT: board_y = Y_BOT, go to REST_BOT.
  - otherwise: board_y += STEP.
- REST_BOT: on tick with trigger = 0, go to UP.
- UP, on tick:
  - trigger = 1: go to DOWN. board_y is unchanged.
  - otherwise, if board_y <= Y_TOP + STEP: board_y = Y_TOP, go to REST_TOP.
  - otherwise: board_y -= STEP.
- moving is registered from the next state, so it is 1 exactly while the state is DOWN or UP.
- board_y never leaves [Y_TOP, Y_BOT]. Comparisons are done in 11-bit unsigned arithmetic, so there is no wrap.
- is_board = 1 iff BOARD_X <= DrawX < BOARD_X+BOARD_W and board_y <= DrawY < board_y+BOARD_H.
- board_address = (DrawX-BOARD_X) + (DrawY-board_y)*BOARD_W, truncated to 10 bits; maximum value 815.
- board_address and is_board are valid in the same cycle as DrawX and DrawY: zero latency, and they reflect the current registered board_y.
- trigger is sampled only on ticks; glitches between ticks are ignored.
- Reset mid-motion returns board_y to Y_TOP immediately; the next tick is evaluated from REST_TOP.

Optional Feature:
BOARD_HOLD_EN
- Defined:
  - On entering REST_BOT, the hold counter loads HOLD_FRAMES.
  - Each tick in REST_BOT decrements the counter, saturating at 0.
  - The REST_BOT to UP transition requires trigger = 0 AND counter = 0. So the board stays down at least HOLD_FRAMES ticks after arrival, even if the player leaves the button.
- Undefined: the counter logic is absent and REST_BOT exits on the first tick with trigger = 0.

Test Plan:
- Reset held 2 cycles -> board_y = 204, moving = 0, state REST_TOP; DrawX = 556, DrawY = 204 gives is_board = 1, board_address = 0.
- trigger = 1, 25 frame ticks -> tick 1: DOWN, board_y = 204; ticks 2-25: board_y steps by 2, reaching 252 on tick 25 and entering REST_BOT with moving = 0.
- Board at 220 in DOWN, trigger drops -> next tick: state UP, board_y = 220; following tick: board_y = 218.
- Board at 252, DrawX = 623, DrawY = 263 -> is_board = 1, board_address = 815; DrawY = 264 -> is_board = 0, board_address = 0.
- BOARD_HOLD_EN defined, board reaches bottom, trigger released at once -> board_y stays 252 for 30 ticks, then enters UP on tick 31. Undefined: enters UP on tick 1.
- Reset asserted with board_y = 240 in DOWN -> next Clk: board_y = 204, moving = 0; with trigger = 1, the next tick enters DOWN.
